// File: rtl/mem_bist_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_bist_pkg
// Description : Shared types and constants for mem_bist_ram: the self-test
//               state encoding, per-March-element attribute masks and the
//               self-test length formula.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_bist_pkg;

  // Self-test sequencer states. M0..M5 are the six March C- elements.
  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_M0   = 4'd1,
    ST_M1   = 4'd2,
    ST_M2   = 4'd3,
    ST_M3   = 4'd4,
    ST_M4   = 4'd5,
    ST_M5   = 4'd6,
    ST_DONE = 4'd7
  } state_t;

  // Per-element attributes, bit i describes element Mi.
  // Bits 6 and 7 are zero so the non-element states never enable anything.
  localparam logic [7:0] C_ELEM_DOWN   = 8'b0001_1000; // M3, M4 sweep N-1..0
  localparam logic [7:0] C_ELEM_HAS_RD = 8'b0011_1110; // M1..M5 read first
  localparam logic [7:0] C_ELEM_RD_ONE = 8'b0001_0100; // M2, M4 expect ones
  localparam logic [7:0] C_ELEM_HAS_WR = 8'b0001_1111; // M0..M4 write
  localparam logic [7:0] C_ELEM_WR_ONE = 8'b0000_1010; // M1, M3 write ones

  // Element index of a state: M0 -> 0 ... M5 -> 5. IDLE maps to 7 and
  // DONE to 6, both of which hit all-zero mask bits.
  function automatic logic [2:0] elem_idx(input state_t s);
    logic [3:0] d;
    d = s - 4'd1;
    return d[2:0];
  endfunction

  // Total cycles bist_busy stays high for a 2**adr_size word memory.
  function automatic int unsigned bist_len(input int unsigned adr_size);
    return 10 * (2 ** adr_size) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bist_ram_array.sv
`default_nettype none
// ============================================================================
// Module      : mem_array
// Description : Single-port storage with synchronous write and two registered
//               read outputs (functional and self-test) sharing one address.
//               A stuck-at-0 fault on bit 0 of one word can be injected on
//               the read path.
// Revision    : 1.0 - initial release
// Ports       : clk, rst_n   - clock, async active-low reset (output regs only)
//               adr          - shared access address
//               we, wdata    - write strobe and data
//               func_re      - load func_q with the addressed word
//               bist_re      - load bist_q with the addressed word
//               inj_en/adr   - force bit 0 of word inj_adr to read as 0
//               func_q       - functional read register
//               bist_q       - self-test read register
// ============================================================================
module mem_array #(
  parameter int ADR_SIZE = 4,
  parameter int DTA_SIZE = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADR_SIZE-1:0] adr,
  input  logic                we,
  input  logic [DTA_SIZE-1:0] wdata,
  input  logic                func_re,
  input  logic                bist_re,
  input  logic                inj_en,
  input  logic [ADR_SIZE-1:0] inj_adr,
  output logic [DTA_SIZE-1:0] func_q,
  output logic [DTA_SIZE-1:0] bist_q
);

  localparam int DEPTH = 1 << ADR_SIZE;

  logic [DTA_SIZE-1:0] r_mem [0:DEPTH-1];
  logic [DTA_SIZE-1:0] w_rword;

  // Fault mux sits before the output registers so every read path sees it.
  always_comb begin
    w_rword = r_mem[adr];
    if (inj_en && (adr == inj_adr)) begin
      w_rword[0] = 1'b0;
    end
  end

  // Storage is deliberately not reset. A simultaneous read sees the old word
  // because the read registers sample before this write lands.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[adr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      func_q <= '0;
      bist_q <= '0;
    end else begin
      if (func_re) begin
        func_q <= w_rword;
      end
      if (bist_re) begin
        bist_q <= w_rword;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_bist_ram.sv
`default_nettype none
// ============================================================================
// Module      : mem_bist_ram
// Description : Parametrised single-port RAM with a March C- self-test engine.
//               Functional access is allowed while the engine is idle or
//               done; a run sweeps every address and reports pass/fail plus
//               the first failing address.
// Revision    : 1.0 - initial release
// Ports       : clk, rst_n            - clock, async active-low reset
//               adress, wr_en, read_en, wr_data - functional access
//               rd_data, rd_valid     - registered read data and its strobe
//               bist_start            - start request (IDLE/DONE only)
//               bist_busy, bist_done  - engine status
//               bist_pass             - result, valid while bist_done
//               bist_fail_adr         - first failing address
//               inj_en, inj_adr       - stuck-at-0 injection on bit 0
// ============================================================================
module mem_bist_ram
  import mem_bist_pkg::*;
#(
  parameter int ADR_SIZE = 4,
  parameter int DTA_SIZE = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADR_SIZE-1:0] adress,
  input  logic                wr_en,
  input  logic                read_en,
  input  logic [DTA_SIZE-1:0] wr_data,
  output logic [DTA_SIZE-1:0] rd_data,
  output logic                rd_valid,
  input  logic                bist_start,
  output logic                bist_busy,
  output logic                bist_done,
  output logic                bist_pass,
  output logic [ADR_SIZE-1:0] bist_fail_adr,
  input  logic                inj_en,
  input  logic [ADR_SIZE-1:0] inj_adr
);

  localparam logic [ADR_SIZE-1:0] C_ADR_ONE = {{(ADR_SIZE-1){1'b0}}, 1'b1};

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADR_SIZE-1:0] r_bist_adr;
  logic                r_phase;     // 1: write half of r/w pair, or M5 tail
  logic                r_cmp_vld;   // a self-test read is returning now
  logic                r_cmp_exp;   // expected background of that read
  logic [ADR_SIZE-1:0] r_cmp_adr;
  logic                r_pass;
  logic [ADR_SIZE-1:0] r_fail_adr;
  logic                r_rd_valid;

  logic                w_busy;
  logic                w_start;
  logic [2:0]          w_idx;
  logic [2:0]          w_nxt_idx;
  logic                w_down;
  logic                w_has_rd;
  logic                w_has_wr;
  logic                w_rd_one;
  logic                w_wr_one;
  logic                w_last;
  logic                w_bist_re;
  logic                w_bist_we;
  logic                w_mismatch;

  logic [ADR_SIZE-1:0] w_arr_adr;
  logic                w_arr_we;
  logic [DTA_SIZE-1:0] w_arr_wdata;
  logic                w_func_re;
  logic [DTA_SIZE-1:0] w_func_q;
  logic [DTA_SIZE-1:0] w_bist_q;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (bist_start) begin
          w_state_nxt = ST_M0;
        end
      end
      ST_M0, ST_M1, ST_M2, ST_M3, ST_M4: begin
        // Elements end on the write to their final address.
        if (w_bist_we && w_last) begin
          w_state_nxt = state_t'(r_state + 4'd1);
        end
      end
      ST_M5: begin
        // Phase is set only for the compare of the last M5 read.
        if (r_phase) begin
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output / operation decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_busy  = 1'b0;
    w_start = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE:                           w_start = bist_start;
      ST_M0, ST_M1, ST_M2, ST_M3, ST_M4, ST_M5: w_busy  = 1'b1;
      default: ;
    endcase
    w_idx     = elem_idx(r_state);
    w_nxt_idx = w_idx + 3'd1;
    w_down    = C_ELEM_DOWN[w_idx];
    w_has_rd  = C_ELEM_HAS_RD[w_idx];
    w_has_wr  = C_ELEM_HAS_WR[w_idx];
    w_rd_one  = C_ELEM_RD_ONE[w_idx];
    w_wr_one  = C_ELEM_WR_ONE[w_idx];
    w_last    = w_down ? (r_bist_adr == '0) : (r_bist_adr == '1);
    w_bist_re = w_busy & w_has_rd & ~r_phase;
    w_bist_we = w_busy & w_has_wr & (~w_has_rd | r_phase);
  end

  assign w_mismatch = r_cmp_vld && (w_bist_q != {DTA_SIZE{r_cmp_exp}});

  // --------------------------------------------------------------------------
  // Address sequencing, compare pipeline and result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bist_adr <= '0;
      r_phase    <= 1'b0;
      r_cmp_vld  <= 1'b0;
      r_cmp_exp  <= 1'b0;
      r_cmp_adr  <= '0;
      r_pass     <= 1'b0;
      r_fail_adr <= '0;
    end else if (w_start) begin
      r_bist_adr <= '0;
      r_phase    <= 1'b0;
      r_cmp_vld  <= 1'b0;
      r_pass     <= 1'b1;
      r_fail_adr <= '0;
    end else if (w_busy) begin
      r_cmp_vld <= w_bist_re;
      r_cmp_exp <= w_rd_one;
      r_cmp_adr <= r_bist_adr;

      if (w_bist_we) begin
        r_phase <= 1'b0;
        if (w_last) begin
          // Jump straight to the first address of the next element.
          r_bist_adr <= C_ELEM_DOWN[w_nxt_idx] ? '1 : '0;
        end else if (w_down) begin
          r_bist_adr <= r_bist_adr - C_ADR_ONE;
        end else begin
          r_bist_adr <= r_bist_adr + C_ADR_ONE;
        end
      end else if (w_bist_re) begin
        if (w_has_wr) begin
          r_phase <= 1'b1;
        end else if (w_last) begin
          r_phase <= 1'b1;           // one extra cycle to compare the last read
        end else begin
          r_bist_adr <= r_bist_adr + C_ADR_ONE;
        end
      end else begin
        r_phase <= 1'b0;
      end

      if (w_mismatch) begin
        r_pass <= 1'b0;
        if (r_pass) begin
          r_fail_adr <= r_cmp_adr;    // only the first mismatch is recorded
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_func_re;
    end
  end

  // --------------------------------------------------------------------------
  // Storage port muxing: the engine owns the array while busy
  // --------------------------------------------------------------------------
  assign w_arr_adr   = w_busy ? r_bist_adr : adress;
  assign w_arr_we    = w_busy ? w_bist_we : wr_en;
  assign w_arr_wdata = w_busy ? {DTA_SIZE{w_wr_one}} : wr_data;
  assign w_func_re   = read_en & ~w_busy;

  mem_array #(
    .ADR_SIZE (ADR_SIZE),
    .DTA_SIZE (DTA_SIZE)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .adr     (w_arr_adr),
    .we      (w_arr_we),
    .wdata   (w_arr_wdata),
    .func_re (w_func_re),
    .bist_re (w_bist_re),
    .inj_en  (inj_en),
    .inj_adr (inj_adr),
    .func_q  (w_func_q),
    .bist_q  (w_bist_q)
  );

  assign rd_data       = w_func_q;
  assign rd_valid      = r_rd_valid;
  assign bist_busy     = w_busy;
  assign bist_done     = (r_state == ST_DONE);
  assign bist_pass     = r_pass & (r_state == ST_DONE);
  assign bist_fail_adr = r_fail_adr;

endmodule
`default_nettype wire

// File: tb/tb_mem_bist_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bist_ram
// Description : Self-checking bench for mem_bist_ram (default 16x8 instance
//               plus an 8x16 instance).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bist_ram;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  adress;
  logic        wr_en, read_en;
  logic [7:0]  wr_data;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        bist_start, bist_busy, bist_done, bist_pass;
  logic [3:0]  bist_fail_adr;
  logic        inj_en;
  logic [3:0]  inj_adr;

  logic [2:0]  b_adress;
  logic        b_wr_en, b_read_en;
  logic [15:0] b_wr_data, b_rd_data;
  logic        b_rd_valid;
  logic        b_start, b_busy, b_done, b_pass;
  logic [2:0]  b_fail_adr;
  logic        b_inj_en;
  logic [2:0]  b_inj_adr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bist_ram #(.ADR_SIZE(4), .DTA_SIZE(8)) dut (
    .clk (clk), .rst_n (rst_n), .adress (adress), .wr_en (wr_en),
    .read_en (read_en), .wr_data (wr_data), .rd_data (rd_data),
    .rd_valid (rd_valid), .bist_start (bist_start), .bist_busy (bist_busy),
    .bist_done (bist_done), .bist_pass (bist_pass),
    .bist_fail_adr (bist_fail_adr), .inj_en (inj_en), .inj_adr (inj_adr)
  );

  mem_bist_ram #(.ADR_SIZE(3), .DTA_SIZE(16)) dut_b (
    .clk (clk), .rst_n (rst_n), .adress (b_adress), .wr_en (b_wr_en),
    .read_en (b_read_en), .wr_data (b_wr_data), .rd_data (b_rd_data),
    .rd_valid (b_rd_valid), .bist_start (b_start), .bist_busy (b_busy),
    .bist_done (b_done), .bist_pass (b_pass),
    .bist_fail_adr (b_fail_adr), .inj_en (b_inj_en), .inj_adr (b_inj_adr)
  );

  // Reference model state for the default instance.
  logic [7:0] ref_mem [16];
  logic [7:0] exp_data;
  logic       exp_valid;

  typedef struct {
    logic       we;
    logic       re;
    logic [3:0] adr;
    logic [7:0] wd;
    logic       ev;
    logic [7:0] ed;
  } vec_t;
  vec_t vecs [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Runs one self-test on the default instance. bist_start is held for the
  // first `hold` busy cycles; at busy cycle `lock` a functional write/read is
  // attempted that must be ignored.
  task automatic run_bist(input int hold, input int lock, output int cyc);
    bist_start = 1'b1;
    step();
    cyc = 0;
    while (bist_busy && cyc < 400) begin
      cyc++;
      bist_start = (cyc < hold);
      if (cyc == lock) begin
        wr_en = 1'b1; read_en = 1'b1; adress = 4'd5; wr_data = 8'hFF;
      end else begin
        wr_en = 1'b0; read_en = 1'b0;
      end
      step();
      if (cyc == lock) begin
        chk("lock_rd_valid", 32'(rd_valid), 32'd0);
        chk("lock_rd_hold", 32'(rd_data), 32'(exp_data));
      end
    end
    bist_start = 1'b0; wr_en = 1'b0; read_en = 1'b0;
  endtask

  task automatic func_op(input logic we, input logic re, input logic [3:0] a,
                         input logic [7:0] d);
    logic [7:0] w;
    wr_en = we; read_en = re; adress = a; wr_data = d;
    if (re) begin
      w = ref_mem[a];
      if (inj_en && (a == inj_adr)) w[0] = 1'b0;
      exp_data  = w;
      exp_valid = 1'b1;
    end else begin
      exp_valid = 1'b0;
    end
    if (we) ref_mem[a] = d;
    step();
    chk("func_rd_valid", 32'(rd_valid), 32'(exp_valid));
    chk("func_rd_data", 32'(rd_data), 32'(exp_data));
    wr_en = 1'b0; read_en = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int fails [4];
    logic [3:0] a;

    //                 we    re    adr    wd     ev    ed
    vecs[0] = '{1'b1, 1'b0, 4'd1,  8'h10, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 1'b1, 4'd1,  8'h00, 1'b1, 8'h10};
    vecs[2] = '{1'b1, 1'b1, 4'd1,  8'hA5, 1'b1, 8'h10};
    vecs[3] = '{1'b0, 1'b1, 4'd1,  8'h00, 1'b1, 8'hA5};
    vecs[4] = '{1'b0, 1'b0, 4'd1,  8'h00, 1'b0, 8'hA5};
    vecs[5] = '{1'b0, 1'b1, 4'd2,  8'h00, 1'b1, 8'h00};
    vecs[6] = '{1'b1, 1'b0, 4'd15, 8'h3C, 1'b0, 8'h00};
    vecs[7] = '{1'b0, 1'b1, 4'd15, 8'h00, 1'b1, 8'h3C};

    rst_n = 1'b0; adress = '0; wr_en = 0; read_en = 0; wr_data = '0;
    bist_start = 0; inj_en = 0; inj_adr = '0;
    b_adress = '0; b_wr_en = 0; b_read_en = 0; b_wr_data = '0;
    b_start = 0; b_inj_en = 0; b_inj_adr = '0;
    repeat (2) step();
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_busy", 32'(bist_busy), 32'd0);
    chk("rst_done", 32'(bist_done), 32'd0);
    chk("rst_pass", 32'(bist_pass), 32'd0);
    chk("rst_fail_adr", 32'(bist_fail_adr), 32'd0);
    rst_n = 1'b1;
    repeat (3) step();
    chk("idle_rd_valid", 32'(rd_valid), 32'd0);

    // Passing run with start held into the busy window (must be ignored).
    run_bist(20, -1, cyc);
    chk("bist_len", 32'(cyc), 32'(10 * 16 + 1));
    chk("pass_done", 32'(bist_done), 32'd1);
    chk("pass_pass", 32'(bist_pass), 32'd1);
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    exp_data = 8'h00;
    for (int i = 0; i < 16; i++) func_op(1'b0, 1'b1, 4'(i), 8'h00);

    // Table-driven functional vectors.
    for (int i = 0; i < 8; i++) begin
      wr_en = vecs[i].we; read_en = vecs[i].re;
      adress = vecs[i].adr; wr_data = vecs[i].wd;
      step();
      chk("vec_rd_valid", 32'(rd_valid), 32'(vecs[i].ev));
      if (vecs[i].ev || i == 4) chk("vec_rd_data", 32'(rd_data), 32'(vecs[i].ed));
      if (vecs[i].we) ref_mem[vecs[i].adr] = vecs[i].wd;
    end
    wr_en = 0; read_en = 0;
    exp_data = 8'h3C;

    // Randomized functional traffic with occasional fault injection.
    for (int i = 0; i < 300; i++) begin
      inj_en  = ($urandom_range(0, 3) == 0);
      inj_adr = 4'($urandom_range(0, 15));
      func_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
    end
    inj_en = 0;

    // Functional access attempt during M5, after word 5 has been verified.
    run_bist(1, 155, cyc);
    chk("lock_len", 32'(cyc), 32'd161);
    chk("lock_pass", 32'(bist_pass), 32'd1);
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    func_op(1'b0, 1'b1, 4'd5, 8'h00);

    // Fault injection: first mismatch is the first r1 of the stuck word.
    fails[0] = 9; fails[1] = 3;
    fails[2] = $urandom_range(0, 15); fails[3] = $urandom_range(0, 15);
    for (int k = 0; k < 4; k++) begin
      a = 4'(fails[k]);
      inj_en = 1'b1; inj_adr = a;
      run_bist(1, -1, cyc);
      inj_en = 1'b0;
      chk("fail_len", 32'(cyc), 32'd161);
      chk("fail_done", 32'(bist_done), 32'd1);
      chk("fail_pass", 32'(bist_pass), 32'd0);
      chk("fail_adr", 32'(bist_fail_adr), 32'(a));
    end

    // Asynchronous abort at busy cycle 50, then a clean rerun.
    bist_start = 1'b1;
    step();
    bist_start = 1'b0;
    repeat (49) step();
    chk("abort_pre_busy", 32'(bist_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bist_busy), 32'd0);
    chk("abort_done", 32'(bist_done), 32'd0);
    chk("abort_rd_data", 32'(rd_data), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    exp_data = 8'h00;
    run_bist(1, -1, cyc);
    chk("rerun_len", 32'(cyc), 32'd161);
    chk("rerun_pass", 32'(bist_pass), 32'd1);

    // 8x16 instance.
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    cyc = 0;
    while (b_busy && cyc < 400) begin
      cyc++;
      step();
    end
    chk("b_len", 32'(cyc), 32'(10 * 8 + 1));
    chk("b_done", 32'(b_done), 32'd1);
    chk("b_pass", 32'(b_pass), 32'd1);
    for (int i = 0; i < 8; i++) begin
      b_adress = 3'(i); b_read_en = 1'b1;
      step();
      chk("b_rd_zero", 32'(b_rd_data), 32'h0000);
    end
    b_read_en = 1'b0; b_wr_en = 1'b1; b_adress = 3'd2; b_wr_data = 16'hBEEF;
    step();
    b_wr_en = 1'b0; b_read_en = 1'b1;
    step();
    b_read_en = 1'b0;
    chk("b_rd_data", 32'(b_rd_data), 32'hBEEF);
    chk("b_rd_valid", 32'(b_rd_valid), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_bist_ram.md
# mem_bist_ram

Parametrised single-port synchronous RAM with an integrated March C- built-in self-test engine. It is the next generation of the BIST memory block: width and depth are generic, and the shared tri-state data bus is replaced by separate write and read buses. A controller-driven self-test sweeps every address and reports pass/fail plus the first failing address. The block sits beside the CPU datapath as working storage and is self-tested after reset under control of the test controller.

## Interface
- ADR_SIZE, 4, address width; depth N = 2^ADR_SIZE
- DTA_SIZE, 8, data word width

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous reset, active-low
- adress  in  ADR_SIZE  functional access address
- wr_en  in  1  functional write strobe
- read_en  in  1  functional read strobe
- wr_data  in  DTA_SIZE  write data
- rd_data  out  DTA_SIZE  registered read data; reset 0
- rd_valid  out  1  one-cycle pulse, rd_data updated; reset 0
- bist_start  in  1  start self-test (level sampled in IDLE/DONE)
- bist_busy  out  1  self-test running; reset 0
- bist_done  out  1  self-test finished, result valid; reset 0
- bist_pass  out  1  1 = no mismatch; valid while bist_done; reset 0
- bist_fail_adr  out  ADR_SIZE  first failing address; reset 0
- inj_en  in  1  fault injection enable (verification hook)
- inj_adr  in  ADR_SIZE  word whose bit 0 reads stuck-at-0 while inj_en=1

## Operation
- Functional mode (IDLE or DONE): wr_en=1 writes wr_data to adress at the edge; read_en=1 registers mem[adress] into rd_data, rd_valid=1 next cycle.
- wr_en and read_en both 1, same address: read-before-write; rd_data gets the old word.
- Neither strobe: rd_data holds, rd_valid=0.
- While bist_busy=1, functional strobes are ignored; rd_data holds; rd_valid=0.
- FSM states: IDLE, M0..M5, DONE.
  - IDLE/DONE + bist_start=1 -> M0; clears bist_done, sets bist_pass=1 internally, clears bist_fail_adr.
  - M0 ⇑(w0); M1 ⇑(r0,w1); M2 ⇑(r1,w0); M3 ⇓(r0,w1); M4 ⇓(r1,w0); M5 ⇑(r0); then DONE.
  - w0/w1 write all-zeros/all-ones words. ⇑ means address 0..N-1; ⇓ means N-1..0.
  - Each operation takes one cycle. Read-then-write elements spend 2 cycles per address.
- Compare: the read is issued in cycle t. In cycle t+1 the returned word is compared with the expected background.
  - On mismatch, bist_pass clears (sticky).
  - bist_fail_adr captures the address of the first mismatch only.
  - The test always runs to completion.
- After a passing BIST, every word holds 0.
- inj_en applies to all reads, both functional and BIST. It forces bit 0 of mem[inj_adr] to read 0.
- The memory array itself is not reset.

## Timing
- Read latency is 1 cycle. Write takes effect at the edge where wr_en is sampled.
- bist_busy rises on the edge after bist_start is sampled. It stays high for exactly 10N+1 cycles: M0 N, M1..M4 2N each, M5 N, plus 1 final compare cycle.
- bist_done rises in the same edge that busy falls. It holds until the next accepted bist_start.
- bist_start while busy is ignored.
- rst_n low at any time, including mid-BIST: all outputs go to reset values immediately and FSM returns to IDLE. Memory contents are undefined after a mid-BIST abort.
- Address counters wrap only at element boundaries. Going from the last address of one element to the first address of the next costs no extra cycle.

## Structure
- Package mem_bist_pkg:
  - state enum (IDLE, M0..M5, DONE)
  - per-element constants: direction, has-read, expected-read value, write value
  - BIST length function 10*(2**ADR_SIZE)+1
- Sub-module mem_array: parametrised storage with synchronous write, registered read, and the fault-injection mux.
- Top level holds the FSM, address counter, op phase bit, compare pipeline register, and result registers.

## Test plan
- Reset then idle: outputs all 0; rd_valid stays 0 with no strobes.
- Functional write/read: write 8'h10 to adress 1, read adress 1 -> next cycle rd_data=8'h10, rd_valid=1. Same-cycle write 8'hA5 plus read -> rd_data=8'h10.
- BIST pass, default params: pulse bist_start -> busy high exactly 161 cycles, then done=1, pass=1. Functional reads of 0..15 return 0.
- BIST fail: inj_en=1, inj_adr=4'd9 -> done=1, pass=0, fail_adr=9. A second start with inj_adr=3 -> fail_adr=3 (cleared between runs).
- Lockout and reset: wr_en pulse with 8'hFF during busy has no effect (word is 0 after pass). rst_n low at cycle 50 of BIST -> busy=0, done=0 asynchronously. A new start then completes normally.
- Parametrisation: ADR_SIZE=3, DTA_SIZE=16 -> busy for 81 cycles, pass=1, backgrounds 16'h0000/16'hFFFF.
